// File: rtl/video_timing_pkg.sv
// Shared constants, vertical state encoding and mode lookups for the
// MrLaggy raster timing generator.
package video_timing_pkg;

  // Default clk cycles per pixel at 15 kHz (scandouble uses half of this)
  localparam int VTG_CE_DIV   = 4;

  // Horizontal timing defaults (pixels); H_TOTAL = 400
  localparam int VTG_H_ACTIVE = 320;
  localparam int VTG_H_FP     = 16;
  localparam int VTG_H_SYNC   = 32;
  localparam int VTG_H_BP     = 32;

  // Vertical porch/sync lengths, shared by NTSC and PAL
  localparam int V_FP   = 3;
  localparam int V_SYNC = 3;

  localparam logic [9:0] V_ACTIVE_NTSC = 10'd240;
  localparam logic [9:0] V_TOTAL_NTSC  = 10'd262;
  localparam logic [9:0] V_ACTIVE_PAL  = 10'd288;
  localparam logic [9:0] V_TOTAL_PAL   = 10'd312;

  typedef enum logic [1:0] {
    V_ACT   = 2'd0,
    V_FRONT = 2'd1,
    V_SYN   = 2'd2,
    V_BACK  = 2'd3
  } vstate_t;

  function automatic logic [9:0] v_total(input logic i_pal);
    return i_pal ? V_TOTAL_PAL : V_TOTAL_NTSC;
  endfunction

  function automatic logic [9:0] v_active(input logic i_pal);
    return i_pal ? V_ACTIVE_PAL : V_ACTIVE_NTSC;
  endfunction

endpackage

// File: rtl/video_ce_gen.sv
// Pixel clock-enable divider: one-clk ce every CE_DIV clks, or every
// CE_DIV/2 clks when i_half is set. o_tick is the combinational early
// version of o_ce so the timing counters can update on the same edge
// at which o_ce rises.
module video_ce_gen #(
  parameter int CE_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_half,
  output logic o_tick,
  output logic o_ce
);

  localparam int CW = (CE_DIV > 2) ? $clog2(CE_DIV) : 1;
  localparam logic [CW-1:0] LAST_FULL = CW'(CE_DIV - 1);
  localparam logic [CW-1:0] LAST_HALF = CW'(CE_DIV / 2 - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_last;

  // Terminal count for the selected rate; tick fires on the last clk of a pixel
  always_comb begin
    w_last = LAST_FULL;
    if (i_half) begin
      w_last = LAST_HALF;
    end else begin
      w_last = LAST_FULL;
    end
    o_tick = (r_cnt == w_last);
  end

  // Divider counter and registered ce strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      o_ce  <= 1'b0;
    end else if (o_tick) begin
      r_cnt <= '0;
      o_ce  <= 1'b1;
    end else begin
      r_cnt <= r_cnt + CW'(1);
      o_ce  <= 1'b0;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: NTSC/PAL 15 kHz or 31 kHz scandoubled timing,
// pixel/line counters and a frame-start strobe. All timing outputs are
// registered and change together with the rising ce_pix.
// Optional feature: define VTG_FRAME_CNT_EN to enable the 16-bit frame_cnt
// counter; otherwise frame_cnt is tied to zero.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int CE_DIV   = VTG_CE_DIV,
  parameter int H_ACTIVE = VTG_H_ACTIVE,
  parameter int H_FP     = VTG_H_FP,
  parameter int H_SYNC   = VTG_H_SYNC,
  parameter int H_BP     = VTG_H_BP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pal,
  input  logic        scandouble,
  output logic        ce_pix,
  output logic [9:0]  hcount,
  output logic [9:0]  vcount,
  output logic        HBlank,
  output logic        HSync,
  output logic        VBlank,
  output logic        VSync,
  output logic        frame_start,
  output logic        pal_active,
  output logic [15:0] frame_cnt
);

  localparam int         H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] HB_START = 10'(H_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);

  logic       r_pal, r_dbl, r_phase;
  logic [9:0] r_hcount, r_vcount;
  logic       r_hblank, r_hsync, r_vblank, r_vsync, r_frame_start;
  vstate_t    r_vstate, w_vstate_next;

  logic       w_tick, w_ce;
  logic [9:0] w_hnext, w_vnext, w_vtotal, w_vactive, w_vs_start, w_vs_end;
  logic       w_phase_next, w_hwrap, w_line_adv, w_frame_end;

  video_ce_gen #(.CE_DIV(CE_DIV)) u_ce_gen (
    .clk    (clk),
    .reset  (reset),
    .i_half (r_dbl),
    .o_tick (w_tick),
    .o_ce   (w_ce)
  );

  // Next-position arithmetic: horizontal wrap, line-double phase, vertical advance
  always_comb begin
    w_vtotal    = v_total(r_pal);
    w_vactive   = v_active(r_pal);
    w_vs_start  = w_vactive + 10'(V_FP);
    w_vs_end    = w_vactive + 10'(V_FP + V_SYNC);
    w_hwrap     = (r_hcount == H_LAST);
    w_line_adv  = w_hwrap && (!r_dbl || r_phase);
    w_frame_end = w_line_adv && (r_vcount == (w_vtotal - 10'd1));
    w_hnext     = w_hwrap ? 10'd0 : (r_hcount + 10'd1);
    if (w_hwrap && r_dbl) begin
      w_phase_next = !r_phase;
    end else if (w_hwrap) begin
      w_phase_next = 1'b0;
    end else begin
      w_phase_next = r_phase;
    end
    if (w_frame_end) begin
      w_vnext = 10'd0;
    end else if (w_line_adv) begin
      w_vnext = r_vcount + 10'd1;
    end else begin
      w_vnext = r_vcount;
    end
  end

  // Vertical FSM next state, evaluated against the line about to start
  always_comb begin
    w_vstate_next = r_vstate;
    if (w_tick && w_line_adv) begin
      case (r_vstate)
        V_ACT:   w_vstate_next = (w_vnext == w_vactive)  ? V_FRONT : V_ACT;
        V_FRONT: w_vstate_next = (w_vnext == w_vs_start) ? V_SYN   : V_FRONT;
        V_SYN:   w_vstate_next = (w_vnext == w_vs_end)   ? V_BACK  : V_SYN;
        V_BACK:  w_vstate_next = (w_vnext == 10'd0)      ? V_ACT   : V_BACK;
        default: w_vstate_next = V_ACT;
      endcase
    end else begin
      w_vstate_next = r_vstate;
    end
  end

  // Vertical FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vstate <= V_ACT;
    end else begin
      r_vstate <= w_vstate_next;
    end
  end

  // Counters, sync/blank decode and mode latch, all advanced on the pixel tick
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hcount      <= 10'd0;
      r_vcount      <= 10'd0;
      r_phase       <= 1'b0;
      r_hblank      <= 1'b0;
      r_hsync       <= 1'b0;
      r_vblank      <= 1'b0;
      r_vsync       <= 1'b0;
      r_frame_start <= 1'b0;
      r_pal         <= pal;
      r_dbl         <= scandouble;
    end else if (w_tick) begin
      r_hcount      <= w_hnext;
      r_vcount      <= w_vnext;
      r_phase       <= w_phase_next;
      r_hblank      <= (w_hnext >= HB_START);
      r_hsync       <= (w_hnext >= HS_START) && (w_hnext < HS_END);
      r_vblank      <= (w_vstate_next != V_ACT);
      r_vsync       <= (w_vstate_next == V_SYN);
      r_frame_start <= (w_hnext == 10'd0) && (w_vnext == 10'd0) && !w_phase_next;
      if (w_frame_end) begin
        r_pal <= pal;
        r_dbl <= scandouble;
      end
    end else begin
      r_frame_start <= 1'b0;
    end
  end

`ifdef VTG_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Frames since reset; bumps the clk after each frame_start, wraps naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_cnt <= 16'd0;
    end else if (r_frame_start) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`else
  assign frame_cnt = 16'd0;
`endif

  assign ce_pix      = w_ce;
  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign HBlank      = r_hblank;
  assign HSync       = r_hsync;
  assign VBlank      = r_vblank;
  assign VSync       = r_vsync;
  assign frame_start = r_frame_start;
  assign pal_active  = r_pal;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen. u_dut uses the default geometry for
// horizontal/ce checks; u_small shrinks the line to 14 pixels (CE_DIV=2)
// so whole NTSC/PAL frames fit in a short run: NTSC frame 262*14*2 = 7336
// clk, PAL frame 312*14*2 = 8736 clk, HBlank from hcount 8, HSync 10..11.
module tb_video_timing_gen;

  logic clk = 1'b0;
  logic reset, pal, scandouble;

  logic        d_ce, d_hb, d_hs, d_vb, d_vs, d_fs, d_pa;
  logic [9:0]  d_h, d_v;
  logic [15:0] d_fc;
  logic        s_ce, s_hb, s_hs, s_vb, s_vs, s_fs, s_pa;
  logic [9:0]  s_h, s_v;
  logic [15:0] s_fc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  video_timing_gen u_dut (
    .clk(clk), .reset(reset), .pal(pal), .scandouble(scandouble),
    .ce_pix(d_ce), .hcount(d_h), .vcount(d_v), .HBlank(d_hb), .HSync(d_hs),
    .VBlank(d_vb), .VSync(d_vs), .frame_start(d_fs), .pal_active(d_pa),
    .frame_cnt(d_fc)
  );

  video_timing_gen #(.CE_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2)) u_small (
    .clk(clk), .reset(reset), .pal(pal), .scandouble(scandouble),
    .ce_pix(s_ce), .hcount(s_h), .vcount(s_v), .HBlank(s_hb), .HSync(s_hs),
    .VBlank(s_vb), .VSync(s_vs), .frame_start(s_fs), .pal_active(s_pa),
    .frame_cnt(s_fc)
  );

  task automatic do_reset(input logic p, input logic d);
    pal = p; scandouble = d; reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    int d_first, s_first;
    pal = 1'b1; scandouble = 1'b0; reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if ({d_ce, d_hb, d_hs, d_vb, d_vs, d_fs} !== 6'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 000000", {d_ce, d_hb, d_hs, d_vb, d_vs, d_fs}); end
    n_checks++; if ({d_h, d_v} !== 20'd0) begin n_fail++; $display("FAIL reset_counts: got h=%0d v=%0d expected 0 0", d_h, d_v); end
    n_checks++; if (d_fc !== 16'd0) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d expected 0", d_fc); end
    n_checks++; if (d_pa !== 1'b1) begin n_fail++; $display("FAIL reset_pal_latch: got %b expected 1", d_pa); end
    reset = 1'b0;
    d_first = 0; s_first = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (d_ce && d_first == 0) d_first = n;
      if (s_ce && s_first == 0) s_first = n;
    end
    n_checks++; if (d_first != 4) begin n_fail++; $display("FAIL first_ce_div4: got %0d expected 4", d_first); end
    n_checks++; if (s_first != 2) begin n_fail++; $display("FAIL first_ce_div2: got %0d expected 2", s_first); end
    n_checks++; if (d_h !== 10'd5) begin n_fail++; $display("FAIL hcount_after_20clk: got %0d expected 5", d_h); end
    n_checks++; if (s_h !== 10'd10) begin n_fail++; $display("FAIL small_hcount_after_20clk: got %0d expected 10", s_h); end
  endtask

  task automatic test_hsync();
    int n, hs_first, hs_last, hs_cnt, hb_first, wrap_at;
    do_reset(1'b0, 1'b0);
    n = 0; hs_first = -1; hs_last = -1; hs_cnt = 0; hb_first = -1; wrap_at = 0;
    while (wrap_at == 0 && n < 2000) begin
      @(posedge clk); #1; n++;
      if (d_ce) begin
        if (d_hs) begin
          if (hs_first < 0) hs_first = int'(d_h);
          hs_last = int'(d_h); hs_cnt++;
        end
        if (d_hb && hb_first < 0) hb_first = int'(d_h);
        if (d_h == 10'd0) wrap_at = n;
      end
    end
    n_checks++; if (wrap_at != 1600) begin n_fail++; $display("FAIL line_clk: got %0d expected 1600", wrap_at); end
    n_checks++; if (d_v !== 10'd1) begin n_fail++; $display("FAIL vcount_after_line: got %0d expected 1", d_v); end
    n_checks++; if (hs_first != 336) begin n_fail++; $display("FAIL hsync_first: got %0d expected 336", hs_first); end
    n_checks++; if (hs_last != 367) begin n_fail++; $display("FAIL hsync_last: got %0d expected 367", hs_last); end
    n_checks++; if (hs_cnt != 32) begin n_fail++; $display("FAIL hsync_len: got %0d expected 32", hs_cnt); end
    n_checks++; if (hb_first != 320) begin n_fail++; $display("FAIL hblank_first: got %0d expected 320", hb_first); end
  endtask

  task automatic test_ntsc_frames();
    int n, frames, last_fs, vs_v, vs_h, vs_px, vb_first, vmax, fc_exp;
    do_reset(1'b0, 1'b0);
    n = 0; frames = 0; last_fs = 0; vs_v = -1; vs_h = -1; vs_px = 0; vb_first = -1; vmax = 0;
    while (frames < 3 && n < 25000) begin
      @(posedge clk); #1; n++;
      if (s_ce && frames == 0) begin
        if (s_vs) begin
          if (vs_v < 0) begin vs_v = int'(s_v); vs_h = int'(s_h); end
          vs_px++;
        end
        if (s_vb && vb_first < 0) vb_first = int'(s_v);
        if (int'(s_v) > vmax) vmax = int'(s_v);
      end
      if (s_fs) begin
`ifdef VTG_FRAME_CNT_EN
        fc_exp = frames;
`else
        fc_exp = 0;
`endif
        n_checks++; if (s_ce !== 1'b1) begin n_fail++; $display("FAIL fs_with_ce: got %b expected 1", s_ce); end
        n_checks++; if (n - last_fs != 7336) begin n_fail++; $display("FAIL ntsc_frame_clk: got %0d expected 7336", n - last_fs); end
        n_checks++; if (s_fc !== 16'(fc_exp)) begin n_fail++; $display("FAIL frame_cnt: got %0d expected %0d", s_fc, fc_exp); end
        last_fs = n; frames++;
      end
    end
    n_checks++; if (frames != 3) begin n_fail++; $display("FAIL ntsc_frames_seen: got %0d expected 3", frames); end
    n_checks++; if (vs_v != 243 || vs_h != 0) begin n_fail++; $display("FAIL vsync_start: got v=%0d h=%0d expected v=243 h=0", vs_v, vs_h); end
    n_checks++; if (vs_px != 42) begin n_fail++; $display("FAIL vsync_pixels: got %0d expected 42", vs_px); end
    n_checks++; if (vb_first != 240) begin n_fail++; $display("FAIL ntsc_vblank_start: got %0d expected 240", vb_first); end
    n_checks++; if (vmax != 261) begin n_fail++; $display("FAIL ntsc_vmax: got %0d expected 261", vmax); end
  endtask

  task automatic test_pal();
    int n, done, vb_first, vs_first, vs_last, vmax;
    do_reset(1'b1, 1'b0);
    n = 0; done = 0; vb_first = -1; vs_first = -1; vs_last = -1; vmax = 0;
    while (done == 0 && n < 10000) begin
      @(posedge clk); #1; n++;
      if (s_ce) begin
        if (s_vb && vb_first < 0) vb_first = int'(s_v);
        if (s_vs) begin
          if (vs_first < 0) vs_first = int'(s_v);
          vs_last = int'(s_v);
        end
        if (int'(s_v) > vmax) vmax = int'(s_v);
      end
      if (s_fs) done = n;
    end
    n_checks++; if (done != 8736) begin n_fail++; $display("FAIL pal_frame_clk: got %0d expected 8736", done); end
    n_checks++; if (vb_first != 288) begin n_fail++; $display("FAIL pal_vblank_start: got %0d expected 288", vb_first); end
    n_checks++; if (vs_first != 291 || vs_last != 293) begin n_fail++; $display("FAIL pal_vsync_lines: got %0d..%0d expected 291..293", vs_first, vs_last); end
    n_checks++; if (vmax != 311) begin n_fail++; $display("FAIL pal_vmax: got %0d expected 311", vmax); end
    n_checks++; if (s_pa !== 1'b1) begin n_fail++; $display("FAIL pal_active: got %b expected 1", s_pa); end
  endtask

  task automatic test_scandouble();
    int n, done, d_c1, d_c2, held5, s_ces;
    do_reset(1'b0, 1'b1);
    n = 0; done = 0; d_c1 = 0; d_c2 = 0; held5 = 0; s_ces = 0;
    while (done == 0 && n < 9000) begin
      @(posedge clk); #1; n++;
      if (d_ce) begin
        if (d_c1 == 0) d_c1 = n;
        else if (d_c2 == 0) d_c2 = n;
      end
      if (s_ce) begin
        s_ces++;
        if (s_v == 10'd5) held5++;
      end
      if (s_fs) done = n;
    end
    n_checks++; if (d_c1 != 2 || d_c2 != 4) begin n_fail++; $display("FAIL dbl_ce_period: got %0d,%0d expected 2,4", d_c1, d_c2); end
    n_checks++; if (held5 != 28) begin n_fail++; $display("FAIL dbl_line_hold: got %0d expected 28", held5); end
    n_checks++; if (s_ces != 7336) begin n_fail++; $display("FAIL dbl_ce_count: got %0d expected 7336", s_ces); end
    n_checks++; if (done != 7336) begin n_fail++; $display("FAIL dbl_frame_clk: got %0d expected 7336", done); end
  endtask

  task automatic test_mode_toggle();
    int n, frames, last_fs, mid_seen;
    do_reset(1'b0, 1'b0);
    n = 0; frames = 0; last_fs = 0; mid_seen = 0;
    while (frames < 2 && n < 16000) begin
      @(posedge clk); #1; n++;
      if (s_ce) begin
        if (frames == 0 && s_v == 10'd100) pal = 1'b1;
        if (frames == 0 && s_v == 10'd150) pal = 1'b0;
        if (frames == 1 && s_v == 10'd100) pal = 1'b1;
        if (frames == 1 && s_v == 10'd200 && s_h == 10'd0) begin
          mid_seen = 1;
          n_checks++; if (s_pa !== 1'b0) begin n_fail++; $display("FAIL pal_midframe_hold: got %b expected 0", s_pa); end
        end
      end
      if (s_fs) begin
        n_checks++; if (n - last_fs != 7336) begin n_fail++; $display("FAIL toggle_frame_clk: got %0d expected 7336", n - last_fs); end
        n_checks++; if (s_pa !== (frames == 1)) begin n_fail++; $display("FAIL pal_active_at_fs: got %b expected %0d", s_pa, frames == 1); end
        last_fs = n; frames++;
      end
    end
    n_checks++; if (frames != 2 || mid_seen != 1) begin n_fail++; $display("FAIL toggle_progress: got frames=%0d mid=%0d expected 2 1", frames, mid_seen); end
  endtask

  task automatic test_reset_mid_vsync();
    int n, d_first, s_first;
    do_reset(1'b0, 1'b0);
    n = 0;
    while (s_vs !== 1'b1 && n < 8000) begin @(posedge clk); #1; n++; end
    n_checks++; if (s_v !== 10'd243) begin n_fail++; $display("FAIL reach_vsync: got v=%0d expected 243", s_v); end
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    n_checks++; if ({s_vs, s_vb, s_hs, s_hb, s_ce, s_fs} !== 6'b0) begin n_fail++; $display("FAIL midreset_flags: got %b expected 000000", {s_vs, s_vb, s_hs, s_hb, s_ce, s_fs}); end
    n_checks++; if ({s_h, s_v} !== 20'd0) begin n_fail++; $display("FAIL midreset_counts: got h=%0d v=%0d expected 0 0", s_h, s_v); end
    d_first = 0; s_first = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (d_ce && d_first == 0) d_first = k;
      if (s_ce && s_first == 0) s_first = k;
    end
    n_checks++; if (s_first != 2 || d_first != 4) begin n_fail++; $display("FAIL midreset_ce_resume: got %0d,%0d expected 2,4", s_first, d_first); end
  endtask

  initial begin
    test_reset();
    test_hsync();
    test_ntsc_frames();
    test_pal();
    test_scandouble();
    test_mode_toggle();
    test_reset_mid_vsync();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
